// File: rtl/cond_exec_unit.sv
// Status register owner, per-channel condition evaluator and IT-block sequencer.
// Channel 0 follows the IT block condition while one is in progress.
module cond_exec_unit #(
    parameter int NUM_CH = 1,
    parameter bit BYPASS = 1'b1,
    parameter bit IT_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flag_we,
    input  logic [3:0]            flag_mask,
    input  logic [3:0]            flag_in,
    output logic [3:0]            status_out,
    input  logic [4*NUM_CH-1:0]   cond_in,
    output logic [NUM_CH-1:0]     cond_pass,
    input  logic                  it_start,
    input  logic [3:0]            it_firstcond,
    input  logic [3:0]            it_mask,
    input  logic                  instr_adv,
    input  logic                  flush,
    output logic                  it_active,
    output logic [3:0]            it_cond,
    output logic [2:0]            it_left,
    output logic                  it_err
);

    typedef enum logic {IDLE, ACTIVE} it_state_t;

    it_state_t  state, state_nxt;
    logic [7:0] itstate, it_nxt;
    logic       err_nxt;
    logic       slot_free;
    logic [3:0] sreg, sreg_nxt, eff;
    logic [3:0] cc;

    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (code)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = !z;
            4'h2:    cond_eval = c;
            4'h3:    cond_eval = !c;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = !n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = !v;
            4'h8:    cond_eval = c & !z;
            4'h9:    cond_eval = !c | z;
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = !z & (n == v);
            4'hD:    cond_eval = z | (n != v);
            4'hE:    cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // The terminating 1 of the mask marks how many instructions remain.
    function automatic logic [2:0] left_of(input logic [3:0] m);
        casez (m)
            4'b???1: left_of = 3'd4;
            4'b??10: left_of = 3'd3;
            4'b?100: left_of = 3'd2;
            4'b1000: left_of = 3'd1;
            default: left_of = 3'd0;
        endcase
    endfunction

    assign sreg_nxt   = flag_we ? ((flag_in & flag_mask) | (sreg & ~flag_mask)) : sreg;
    assign eff        = (BYPASS && flag_we) ? sreg_nxt : sreg;
    assign status_out = sreg;

    always_comb begin
        it_nxt    = itstate;
        err_nxt   = 1'b0;
        slot_free = (state == IDLE);
        if (!IT_EN) begin
            it_nxt = 8'h00;
        end else if (flush) begin
            it_nxt = 8'h00;
        end else begin
            if (state == ACTIVE && instr_adv) begin
                if (itstate[2:0] == 3'b000) begin
                    it_nxt    = 8'h00;
                    slot_free = 1'b1;
                end else begin
                    it_nxt = {itstate[7:5], itstate[3:0], 1'b0};
                end
            end
            // A new block may only start once the previous one has retired.
            if (it_start) begin
                if (slot_free && it_mask != 4'h0 && it_firstcond != 4'hF)
                    it_nxt = {it_firstcond, it_mask};
                else
                    err_nxt = 1'b1;
            end
        end
        state_nxt = (it_nxt[3:0] != 4'h0) ? ACTIVE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= 4'h0;
            itstate   <= 8'h00;
            state     <= IDLE;
            it_active <= 1'b0;
            it_cond   <= 4'h0;
            it_left   <= 3'd0;
            it_err    <= 1'b0;
        end else begin
            sreg      <= sreg_nxt;
            itstate   <= it_nxt;
            state     <= state_nxt;
            it_active <= (state_nxt == ACTIVE);
            it_cond   <= it_nxt[7:4];
            it_left   <= left_of(it_nxt[3:0]);
            it_err    <= err_nxt;
        end
    end

    always_comb begin
        cond_pass = '0;
        cc        = 4'h0;
        for (int k = 0; k < NUM_CH; k++) begin
            cc = cond_in[4*k +: 4];
            if (k == 0 && it_active)
                cc = it_cond;
            cond_pass[k] = cond_eval(cc, eff);
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Bench for cond_exec_unit: a queue-based model of the status flags and IT block
// checked every cycle, plus literal expectations at the interesting points.
module tb_cond_exec_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_we;
    logic [3:0] flag_mask, flag_in;
    logic [7:0] cond_in;
    logic       it_start, instr_adv, flush;
    logic [3:0] it_firstcond, it_mask;

    logic [3:0] status_out, nb_status;
    logic [1:0] cond_pass;
    logic [0:0] nb_pass;
    logic       it_active, it_err, nb_active, nb_err;
    logic [3:0] it_cond, nb_cond;
    logic [2:0] it_left, nb_left;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    logic [3:0] m_sreg;
    logic [3:0] m_q[$];
    bit         m_err;

    always #5 clk = ~clk;

    cond_exec_unit #(.NUM_CH(2), .BYPASS(1'b1), .IT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_mask(flag_mask), .flag_in(flag_in),
        .status_out(status_out), .cond_in(cond_in), .cond_pass(cond_pass),
        .it_start(it_start), .it_firstcond(it_firstcond), .it_mask(it_mask),
        .instr_adv(instr_adv), .flush(flush), .it_active(it_active), .it_cond(it_cond),
        .it_left(it_left), .it_err(it_err)
    );

    cond_exec_unit #(.NUM_CH(1), .BYPASS(1'b0), .IT_EN(1'b1)) dut_nb (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_mask(flag_mask), .flag_in(flag_in),
        .status_out(nb_status), .cond_in(cond_in[3:0]), .cond_pass(nb_pass),
        .it_start(it_start), .it_firstcond(it_firstcond), .it_mask(it_mask),
        .instr_adv(instr_adv), .flush(flush), .it_active(nb_active), .it_cond(nb_cond),
        .it_left(nb_left), .it_err(nb_err)
    );

    // Conditions come in complementary pairs sharing one base predicate.
    function automatic bit model_pass(input logic [3:0] code, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (code == 4'hF) return 1'b0;
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return code[0] ? !base : base;
    endfunction

    function automatic logic [3:0] model_written(input logic [3:0] cur);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = (flag_we && flag_mask[i]) ? flag_in[i] : cur[i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] fm, input logic [3:0] fin,
                                 input logic [7:0] cin, input logic st, input logic [3:0] fc,
                                 input logic [3:0] itm, input logic adv, input logic fl);
        flag_we = we; flag_mask = fm; flag_in = fin; cond_in = cin;
        it_start = st; it_firstcond = fc; it_mask = itm; instr_adv = adv; flush = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: the IT block is a queue of the conditions still to be applied.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_sreg = 4'h0;
                m_q.delete();
                m_err = 1'b0;
            end else begin
                m_sreg = model_written(m_sreg);
                m_err  = 1'b0;
                if (flush) begin
                    m_q.delete();
                end else begin
                    if (instr_adv && m_q.size() > 0)
                        void'(m_q.pop_front());
                    if (it_start) begin
                        if (m_q.size() == 0 && it_mask != 4'h0 && it_firstcond != 4'hF) begin
                            int low = 4;
                            for (int i = 3; i >= 0; i--)
                                if (it_mask[i]) low = i;
                            m_q.push_back(it_firstcond);
                            for (int k = 1; k < 4 - low; k++)
                                m_q.push_back({it_firstcond[3:1], it_mask[4-k]});
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] c0, eff_b;
            logic [1:0] exp_pass;
            bit act;
            act   = (m_q.size() != 0);
            c0    = act ? m_q[0] : cond_in[3:0];
            eff_b = model_written(m_sreg);
            exp_pass = {model_pass(cond_in[7:4], eff_b), model_pass(c0, eff_b)};
            checkOutput("status", {4'h0, status_out}, {4'h0, m_sreg});
            checkOutput("it_active", {7'h0, it_active}, {7'h0, act});
            checkOutput("it_cond", {4'h0, it_cond}, {4'h0, act ? m_q[0] : 4'h0});
            checkOutput("it_left", {5'h0, it_left}, 8'(m_q.size()));
            checkOutput("it_err", {7'h0, it_err}, {7'h0, m_err});
            checkOutput("cond_pass", {6'h0, cond_pass}, {6'h0, exp_pass});
            checkOutput("nb_pass", {7'h0, nb_pass}, {7'h0, model_pass(c0, m_sreg)});
            checkOutput("nb_state", {nb_status, nb_active, nb_left},
                        {m_sreg, act, 3'(m_q.size())});
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 4'h0, 0, 0);
        tick;
        chk_en = 1'b1;
        tick;
        $display("[TB] reset checks");
        checkOutput("rst_status", {4'h0, status_out}, 8'h00);
        checkOutput("rst_active", {7'h0, it_active}, 8'h00);
        checkOutput("rst_err", {7'h0, it_err}, 8'h00);
        checkOutput("rst_eq", {7'h0, cond_pass[0]}, 8'h00);
        rst = 1'b0;

        $display("[TB] masked write and bypass");
        applyStimulus(1, 4'b0100, 4'b1111, 8'h00, 0, 4'h0, 4'h0, 0, 0);
        #1;
        checkOutput("bypass_eq", {7'h0, cond_pass[0]}, 8'h01);
        checkOutput("nobypass_eq", {7'h0, nb_pass}, 8'h00);
        tick;
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 4'h0, 0, 0);
        #1;
        checkOutput("status_0100", {4'h0, status_out}, 8'h04);
        checkOutput("nobypass_eq_next", {7'h0, nb_pass}, 8'h01);
        applyStimulus(1, 4'b0000, 4'b1011, 8'h00, 0, 4'h0, 4'h0, 0, 0);
        tick;
        checkOutput("mask0_hold", {4'h0, status_out}, 8'h04);

        $display("[TB] condition sweep");
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 16; c++) begin
                applyStimulus(1, 4'hF, 4'(f), {4'(c) ^ 4'h5, 4'(c)}, 0, 4'h0, 4'h0, 0, 0);
                tick;
            end
        applyStimulus(1, 4'hF, 4'b0101, 8'h0D, 0, 4'h0, 4'h0, 0, 0);
        #1;
        checkOutput("le_z1_v1", {7'h0, cond_pass[0]}, 8'h01);
        tick;
        applyStimulus(1, 4'hF, 4'b0000, 8'h00, 0, 4'h0, 4'h0, 0, 0);
        tick;

        $display("[TB] ITTE EQ block");
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 1, 4'h0, 4'b0110, 0, 0);
        tick;
        checkOutput("itte_left1", {5'h0, it_left}, 8'd3);
        checkOutput("itte_cond1", {4'h0, it_cond}, 8'h00);
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 4'h0, 1, 0);
        tick;
        checkOutput("itte_left2", {5'h0, it_left}, 8'd2);
        checkOutput("itte_cond2", {4'h0, it_cond}, 8'h00);
        tick;
        checkOutput("itte_left3", {5'h0, it_left}, 8'd1);
        checkOutput("itte_cond3", {4'h0, it_cond}, 8'h01);
        tick;
        checkOutput("itte_done", {it_active, it_left}, 8'h00);

        $display("[TB] flush and illegal starts");
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 1, 4'h1, 4'b0100, 0, 0);
        tick;
        checkOutput("blk_left", {5'h0, it_left}, 8'd2);
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 1, 4'h2, 4'b1000, 0, 0);
        tick;
        checkOutput("nested_err", {it_err, it_active, 3'b0, it_left}, 8'hC2);
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 1, 4'h2, 4'b1000, 0, 1);
        tick;
        checkOutput("flush_start", {it_active, it_err}, 8'h00);
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 1, 4'h2, 4'b0000, 0, 0);
        tick;
        checkOutput("mask0_err", {it_active, it_err}, 8'h01);
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 4'h0, 0, 0);
        tick;
        checkOutput("err_pulse_end", {7'h0, it_err}, 8'h00);
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 1, 4'hF, 4'b1000, 0, 0);
        tick;
        checkOutput("nv_err", {it_active, it_err}, 8'h01);

        $display("[TB] back-to-back blocks");
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 1, 4'h0, 4'b1000, 0, 0);
        tick;
        checkOutput("single_left", {5'h0, it_left}, 8'd1);
        applyStimulus(0, 4'h0, 4'h0, 8'h0F, 1, 4'hA, 4'b1000, 1, 0);
        tick;
        checkOutput("chain", {it_active, it_cond, it_left}, {1'b1, 4'hA, 3'd1});
        checkOutput("chain_err", {7'h0, it_err}, 8'h00);
        applyStimulus(0, 4'h0, 4'h0, 8'h0F, 0, 4'h0, 4'h0, 0, 0);
        #1;
        checkOutput("ch1_no_override", {6'h0, cond_pass}, 8'h01);
        tick;
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 4'h0, 1, 0);
        tick;
        checkOutput("chain_done", {7'h0, it_active}, 8'h00);
        applyStimulus(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 4'h0, 0, 0);
        tick;

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
